t02_writeback_unit: RTL and testbench

T02_WRITEBACK_UNIT -- requirements
Module: t02_writeback_unit

---
 rtl/t02_writeback_unit.sv | 160 ++++++++++++++++
 tb/tb_t02_writeback_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/t02_writeback_unit.sv
// Writeback unit. It merges ALU results with one outstanding load into a
// single registered register-file write port. It also reports a load-use
// hazard against the destination of the pending load.
//
// Handshake: a load is accepted only when ld_issue=1 in IDLE. Memory data
// is taken only when mem_rvalid=1 in WAIT_MEM. Neither input has a ready
// line, so a pulse that arrives in any other state is dropped silently.
module t02_writeback_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             ld_issue,
  input  logic [4:0]       ld_rd,
  input  logic [2:0]       ld_funct3,
  input  logic [1:0]       ld_byte_off,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic [4:0]       rs1_index,
  input  logic [4:0]       rs2_index,
  output logic             reg_write,
  output logic [4:0]       write_index,
  output logic [WIDTH-1:0] write_data,
  output logic             stall,
  output logic             ld_busy
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WB_LOAD} state_t;

  state_t           r_state, w_next_state;
  logic             r_pend_valid, w_pend_valid_next;
  logic [4:0]       r_pend_rd;
  logic [2:0]       r_pend_funct3;
  logic [1:0]       r_pend_off;
  logic [WIDTH-1:0] r_ld_data;
  logic             r_reg_write;
  logic [4:0]       r_write_index;
  logic [WIDTH-1:0] r_write_data;

  logic             w_capture, w_latch;
  logic             w_wr_en;
  logic [4:0]       w_wr_idx;
  logic [WIDTH-1:0] w_wr_data;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [WIDTH-1:0] w_ld_value;

  // Select the addressed byte and halfword, then extend them by load type.
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_pend_off)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_pend_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_pend_funct3)
      3'b000:  w_ld_value = {{(WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_ld_value = {{(WIDTH-16){w_half[15]}}, w_half};
      3'b100:  w_ld_value = {{(WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_ld_value = {{(WIDTH-16){1'b0}}, w_half};
      default: w_ld_value = mem_rdata;
    endcase
  end

  // Next-state logic and write-port arbitration. The ALU always wins the port.
  always_comb begin
    w_next_state      = r_state;
    w_pend_valid_next = r_pend_valid;
    w_capture         = 1'b0;
    w_latch           = 1'b0;
    w_wr_en           = 1'b0;
    w_wr_idx          = r_write_index;
    w_wr_data         = r_write_data;

    if (alu_valid && (alu_rd != 5'd0)) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = alu_rd;
      w_wr_data = alu_result;
    end

    case (r_state)
      IDLE: begin
        if (ld_issue) begin
          w_capture         = 1'b1;
          w_pend_valid_next = (ld_rd != 5'd0);
          w_next_state      = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        // A younger ALU write to the same rd makes the load result stale.
        if (alu_valid && (alu_rd == r_pend_rd)) w_pend_valid_next = 1'b0;
        if (mem_rvalid) begin
          w_latch      = 1'b1;
          w_next_state = WB_LOAD;
        end
      end
      WB_LOAD: begin
        if (alu_valid) begin
          if (alu_rd == r_pend_rd) w_pend_valid_next = 1'b0;
        end else begin
          if (r_pend_valid) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_pend_rd;
            w_wr_data = r_ld_data;
          end
          w_pend_valid_next = 1'b0;
          w_next_state      = IDLE;
        end
      end
      default: begin
        w_pend_valid_next = 1'b0;
        w_next_state      = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Pending-load bookkeeping and the registered write port.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      r_pend_valid  <= 1'b0;
      r_pend_rd     <= 5'd0;
      r_pend_funct3 <= 3'd0;
      r_pend_off    <= 2'd0;
      r_ld_data     <= '0;
      r_reg_write   <= 1'b0;
      r_write_index <= 5'd0;
      r_write_data  <= '0;
    end else begin
      r_pend_valid <= w_pend_valid_next;
      if (w_capture) begin
        r_pend_rd     <= ld_rd;
        r_pend_funct3 <= ld_funct3;
        r_pend_off    <= ld_byte_off;
      end
      if (w_latch) r_ld_data <= w_ld_value;
      r_reg_write   <= w_wr_en;
      r_write_index <= w_wr_idx;
      r_write_data  <= w_wr_data;
    end
  end

  assign reg_write   = r_reg_write;
  assign write_index = r_write_index;
  assign write_data  = r_write_data;
  assign ld_busy     = (r_state != IDLE);
  assign stall       = ld_busy && r_pend_valid && (r_pend_rd != 5'd0) &&
                       ((rs1_index == r_pend_rd) || (rs2_index == r_pend_rd));

endmodule

// File: tb/tb_t02_writeback_unit.sv
// Directed bench for t02_writeback_unit. Inputs change 1 ns after each rising
// edge, and outputs are checked at that same point.
module tb_t02_writeback_unit;

  logic        clk = 1'b0;
  logic        nRST;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_byte_off;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rs1_index, rs2_index;
  logic        reg_write;
  logic [4:0]  write_index;
  logic [31:0] write_data;
  logic        stall, ld_busy;

  int n_tests = 0;
  int n_fail  = 0;

  t02_writeback_unit #(.WIDTH(32)) dut (
    .clk(clk), .nRST(nRST),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
    .ld_byte_off(ld_byte_off), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rs1_index(rs1_index), .rs2_index(rs2_index),
    .reg_write(reg_write), .write_index(write_index), .write_data(write_data),
    .stall(stall), .ld_busy(ld_busy)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] idx, input logic [31:0] data);
    chk({tag, "_we"},   {31'd0, reg_write}, 32'd1);
    chk({tag, "_idx"},  {27'd0, write_index}, {27'd0, idx});
    chk({tag, "_data"}, write_data, data);
  endtask

  // Issue a load, wait one cycle in WAIT_MEM, return data, and run to the writeback cycle.
  task automatic run_load(input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] off, input logic [31:0] rdata);
    ld_issue = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_byte_off = off;
    step();
    ld_issue = 1'b0;
    step();
    mem_rvalid = 1'b1; mem_rdata = rdata;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    step();
  endtask

  initial begin
    nRST = 1'b0; alu_valid = 1'b0; alu_rd = 5'd0; alu_result = 32'd0;
    ld_issue = 1'b0; ld_rd = 5'd0; ld_funct3 = 3'd0; ld_byte_off = 2'd0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0; rs1_index = 5'd0; rs2_index = 5'd0;

    // Reset state
    step(); step();
    chk("rst_we",   {31'd0, reg_write}, 32'd0);
    chk("rst_idx",  {27'd0, write_index}, 32'd0);
    chk("rst_data", write_data, 32'd0);
    chk("rst_busy", {31'd0, ld_busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    nRST = 1'b1;
    step();

    // ALU write, then hold, then rd=0 suppressed
    alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'h0000_1234;
    step();
    alu_valid = 1'b0;
    chk_wr("alu5", 5'd5, 32'h0000_1234);
    step();
    chk("alu_hold_we", {31'd0, reg_write}, 32'd0);
    chk("alu_hold_data", write_data, 32'h0000_1234);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 32'hCAFE_0000;
    step();
    alu_valid = 1'b0;
    chk("alu_r0_we", {31'd0, reg_write}, 32'd0);
    chk("alu_r0_idx", {27'd0, write_index}, 32'd5);
    chk("alu_r0_data", write_data, 32'h0000_1234);

    // Load extraction
    run_load(5'd3, 3'b000, 2'd2, 32'h0080_0000);
    chk_wr("lb", 5'd3, 32'hFFFF_FF80);
    chk("lb_busy", {31'd0, ld_busy}, 32'd0);
    run_load(5'd3, 3'b100, 2'd2, 32'h0080_0000);
    chk_wr("lbu", 5'd3, 32'h0000_0080);
    run_load(5'd11, 3'b000, 2'd1, 32'h0000_7F00);
    chk_wr("lb_pos", 5'd11, 32'h0000_007F);
    run_load(5'd12, 3'b001, 2'd2, 32'h8001_0000);
    chk_wr("lh", 5'd12, 32'hFFFF_8001);
    run_load(5'd13, 3'b101, 2'd0, 32'h1234_8001);
    chk_wr("lhu", 5'd13, 32'h0000_8001);
    run_load(5'd14, 3'b010, 2'd3, 32'h89AB_CDEF);
    chk_wr("lw", 5'd14, 32'h89AB_CDEF);
    run_load(5'd15, 3'b011, 2'd1, 32'h8765_4321);
    chk_wr("lw_other", 5'd15, 32'h8765_4321);

    // Load-use stall on rd=7
    rs1_index = 5'd7;
    chk("stall_idle", {31'd0, stall}, 32'd0);
    ld_issue = 1'b1; ld_rd = 5'd7; ld_funct3 = 3'b010; ld_byte_off = 2'd0;
    step();
    ld_issue = 1'b0;
    chk("stall_wait", {31'd0, stall}, 32'd1);
    rs1_index = 5'd1; rs2_index = 5'd7;
    chk("stall_rs2", {31'd0, stall}, 32'd1);
    rs1_index = 5'd7; rs2_index = 5'd0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
    step();
    mem_rvalid = 1'b0;
    chk("stall_wb", {31'd0, stall}, 32'd1);
    step();
    chk_wr("ld7", 5'd7, 32'h0000_0077);
    chk("stall_done", {31'd0, stall}, 32'd0);

    // rd=0 load: no stall, no write
    rs1_index = 5'd0;
    ld_issue = 1'b1; ld_rd = 5'd0;
    step();
    ld_issue = 1'b0;
    chk("r0_stall", {31'd0, stall}, 32'd0);
    chk("r0_busy", {31'd0, ld_busy}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_00AA;
    step();
    mem_rvalid = 1'b0;
    step();
    chk("r0_we", {31'd0, reg_write}, 32'd0);
    chk("r0_idx", {27'd0, write_index}, 32'd7);
    chk("r0_busy_end", {31'd0, ld_busy}, 32'd0);

    // ALU priority in WB_LOAD
    ld_issue = 1'b1; ld_rd = 5'd4; ld_funct3 = 3'b010;
    step();
    ld_issue = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0011;
    step();
    mem_rvalid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_result = 32'h0000_00A1;
    step();
    chk_wr("pri_a1", 5'd9, 32'h0000_00A1);
    alu_result = 32'h0000_00A2;
    step();
    alu_valid = 1'b0;
    chk_wr("pri_a2", 5'd9, 32'h0000_00A2);
    chk("pri_busy", {31'd0, ld_busy}, 32'd1);
    step();
    chk_wr("pri_ld4", 5'd4, 32'h0000_0011);
    chk("pri_idle", {31'd0, ld_busy}, 32'd0);

    // WAW: ALU write to rd=6 while the rd=6 load waits; a stray ld_issue is ignored
    ld_issue = 1'b1; ld_rd = 5'd6; ld_funct3 = 3'b010;
    step();
    ld_rd = 5'd20;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_result = 32'h0000_0066;
    step();
    ld_issue = 1'b0; alu_valid = 1'b0;
    chk_wr("waw_alu", 5'd6, 32'h0000_0066);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0099;
    step();
    mem_rvalid = 1'b0;
    chk("waw_we1", {31'd0, reg_write}, 32'd0);
    step();
    chk("waw_we2", {31'd0, reg_write}, 32'd0);
    chk("waw_data", write_data, 32'h0000_0066);
    chk("waw_busy", {31'd0, ld_busy}, 32'd0);

    // Simultaneous ld_issue and ALU write in IDLE
    ld_issue = 1'b1; ld_rd = 5'd8; ld_funct3 = 3'b010;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_result = 32'h0000_0022;
    step();
    ld_issue = 1'b0; alu_valid = 1'b0;
    chk_wr("sim_alu", 5'd2, 32'h0000_0022);
    chk("sim_busy", {31'd0, ld_busy}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0005;
    step();
    mem_rvalid = 1'b0;
    step();
    chk_wr("sim_ld8", 5'd8, 32'h0000_0005);

    // Reset during WAIT_MEM, then a late mem_rvalid
    rs1_index = 5'd10;
    ld_issue = 1'b1; ld_rd = 5'd10;
    step();
    ld_issue = 1'b0;
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    chk("mrst_busy", {31'd0, ld_busy}, 32'd0);
    chk("mrst_stall", {31'd0, stall}, 32'd0);
    chk("mrst_we", {31'd0, reg_write}, 32'd0);
    chk("mrst_idx", {27'd0, write_index}, 32'd0);
    chk("mrst_data", write_data, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
    step();
    mem_rvalid = 1'b0;
    step();
    chk("late_we", {31'd0, reg_write}, 32'd0);
    chk("late_busy", {31'd0, ld_busy}, 32'd0);
    chk("late_data", write_data, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
